// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD temperature feeder.
// OPER codes, LCD commands, ASCII glyphs, FSM states, BCD helper.
package lcd_pkg;

  localparam logic [1:0] OPER_IDLE  = 2'd0;
  localparam logic [1:0] OPER_CHAR  = 2'd1;
  localparam logic [1:0] OPER_INSTR = 2'd2;

  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

  localparam logic [7:0] CH_DEG   = 8'hDF;
  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_T     = 8'h54;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_DOT   = 8'h2E;
  localparam logic [7:0] CH_C     = 8'h43;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_ISSUE,
    S_WAIT_LO,
    S_WAIT_HI
  } feed_state_t;

  // Double-dabble correction: add 3 to every BCD digit >= 5.
  function automatic logic [11:0] dd_adj(input logic [11:0] b);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = (b[4*i +: 4] >= 4'd5)
                  ? b[4*i +: 4] + 4'd3
                  : b[4*i +: 4];
    end
    return r;
  endfunction

endpackage

// File: rtl/lcd_temp_feeder_bin2bcd.sv
// Sequential 9-bit binary to 3-digit BCD converter.
// Double-dabble, one bit per cycle; DONE pulses after 9 shifts.
module bin2bcd
  import lcd_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [8:0] BIN,
  output logic       DONE,
  output logic [3:0] HUND,
  output logic [3:0] TENS,
  output logic [3:0] ONES
);

  logic [8:0]  sh;
  logic [11:0] bcd;
  logic [11:0] adj;
  logic [3:0]  cnt;
  logic        run;

  assign adj  = dd_adj(bcd);
  assign HUND = bcd[11:8];
  assign TENS = bcd[7:4];
  assign ONES = bcd[3:0];

  // Load on START, then correct-and-shift one input bit per cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sh   <= '0;
      bcd  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      DONE <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (START) begin
        sh  <= BIN;
        bcd <= '0;
        cnt <= 4'd9;
        run <= 1'b1;
      end else if (run) begin
        {bcd, sh} <= {adj, sh} << 1;
        cnt       <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          run  <= 1'b0;
          DONE <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lcd_temp_feeder.sv
// Formats a 1/16 degC sample as "T=sDDD.F<deg>C" and streams it to the LCD.
// Define LCDFEED_CLEAR_EN to send a CLEAR instruction before each line.
module lcd_temp_feeder
  import lcd_pkg::*;
#(
  parameter int          TEMP_W    = 13,
  parameter logic [6:0]  LINE_ADDR = 7'h00,
  parameter logic [23:0] TO_CYC    = 24'd2_400_000
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic signed [TEMP_W-1:0] TEMP,
  input  logic                     TEMP_VLD,
  input  logic                     LCD_RDY,
  output logic [7:0]               LCD_DATA,
  output logic [1:0]               LCD_OPER,
  output logic                     LCD_ENB,
  output logic                     BUSY,
  output logic                     TO_ERR
);

`ifdef LCDFEED_CLEAR_EN
  localparam int         NITEMS = 12;
  localparam logic [3:0] BASE   = 4'd1;
`else
  localparam int         NITEMS = 11;
  localparam logic [3:0] BASE   = 4'd0;
`endif
  localparam logic [3:0] LAST = 4'(NITEMS - 1);

  feed_state_t       state;
  logic [3:0]        idx;
  logic [3:0]        slot;
  logic [23:0]       cnt;
  logic [TEMP_W-1:0] temp_q;
  logic [TEMP_W-1:0] pend_temp;
  logic              pend_vld;
  logic              bcd_start;
  logic              bcd_done;
  logic [3:0]        d_hund;
  logic [3:0]        d_tens;
  logic [3:0]        d_ones;

  logic              sgn;
  logic [TEMP_W-1:0] mag;
  logic [8:0]        ipart;
  logic [3:0]        fdig;
  logic [1:0]        item_oper;
  logic [7:0]        item_data;

  // Magnitude is unsigned so the most negative sample stays exact.
  assign sgn   = temp_q[TEMP_W-1];
  assign mag   = sgn ? -temp_q : temp_q;
  assign ipart = 9'(mag >> 4);
  assign fdig  = 4'(({4'h0, mag[3:0]} * 8'd10) >> 4);
  assign slot  = idx - BASE;

  bin2bcd u_bcd (
    .CLK   (CLK),
    .RST   (RST),
    .START (bcd_start),
    .BIN   (ipart),
    .DONE  (bcd_done),
    .HUND  (d_hund),
    .TENS  (d_tens),
    .ONES  (d_ones)
  );

  // Select the byte and operation for the current line position.
  always_comb begin
    item_oper = OPER_CHAR;
    item_data = CH_C;
    unique case (slot)
      4'd0: begin
        item_oper = OPER_INSTR;
        item_data = {1'b1, LINE_ADDR};
      end
      4'd1:  item_data = CH_T;
      4'd2:  item_data = CH_EQ;
      4'd3:  item_data = sgn ? CH_MINUS : CH_PLUS;
      4'd4:  item_data = CH_ZERO + {4'h0, d_hund};
      4'd5:  item_data = CH_ZERO + {4'h0, d_tens};
      4'd6:  item_data = CH_ZERO + {4'h0, d_ones};
      4'd7:  item_data = CH_DOT;
      4'd8:  item_data = CH_ZERO + {4'h0, fdig};
      4'd9:  item_data = CH_DEG;
      4'd10: item_data = CH_C;
      default: begin
        item_oper = OPER_INSTR;
        item_data = CMD_CLEAR;
      end
    endcase
  end

  // Capture, convert, then run the ISSUE/WAIT_LO/WAIT_HI handshake per item.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      idx       <= '0;
      cnt       <= '0;
      temp_q    <= '0;
      pend_temp <= '0;
      pend_vld  <= 1'b0;
      bcd_start <= 1'b0;
      LCD_DATA  <= '0;
      LCD_OPER  <= OPER_IDLE;
      LCD_ENB   <= 1'b0;
      BUSY      <= 1'b0;
      TO_ERR    <= 1'b0;
    end else begin
      LCD_ENB   <= 1'b0;
      bcd_start <= 1'b0;
      if (TEMP_VLD && state != S_IDLE) begin
        pend_vld  <= 1'b1;
        pend_temp <= TEMP;
      end
      unique case (state)
        S_IDLE: begin
          if (TEMP_VLD || pend_vld) begin
            temp_q    <= TEMP_VLD ? TEMP : pend_temp;
            pend_vld  <= 1'b0;
            bcd_start <= 1'b1;
            BUSY      <= 1'b1;
            idx       <= '0;
            state     <= S_CONV;
          end
        end
        S_CONV: begin
          if (bcd_done) state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (LCD_RDY) begin
            LCD_DATA <= item_data;
            LCD_OPER <= item_oper;
            LCD_ENB  <= 1'b1;
            cnt      <= '0;
            state    <= S_WAIT_LO;
          end
        end
        S_WAIT_LO: begin
          if (!LCD_RDY) begin
            cnt   <= '0;
            state <= S_WAIT_HI;
          end else if (cnt == TO_CYC) begin
            TO_ERR   <= 1'b1;
            LCD_OPER <= OPER_IDLE;
            BUSY     <= 1'b0;
            cnt      <= '0;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt + 24'd1;
          end
        end
        S_WAIT_HI: begin
          if (LCD_RDY) begin
            cnt <= '0;
            if (idx == LAST) begin
              LCD_OPER <= OPER_IDLE;
              BUSY     <= 1'b0;
              state    <= S_IDLE;
            end else begin
              idx   <= idx + 4'd1;
              state <= S_ISSUE;
            end
          end else if (cnt == TO_CYC) begin
            TO_ERR   <= 1'b1;
            LCD_OPER <= OPER_IDLE;
            BUSY     <= 1'b0;
            cnt      <= '0;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt + 24'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lcd_temp_feeder.md
Name: lcd_temp_feeder

Overview:
- Upstream client of the LCD character controller in the temperature-sensor design.
- Takes a signed fixed-point temperature sample and converts it to a fixed 10-character ASCII line.
- Streams one DDRAM-address instruction plus the characters into the LCD controller over its DATA/OPER/ENB/RDY handshake.
- Sits between the sensor read-out block and the LCD controller.

Parameters:
- TEMP_W, 13, temperature width in bits; two's complement, LSB = 1/16 °C.
- LINE_ADDR, 7'h00, DDRAM start address; the instruction sent is {1'b1, LINE_ADDR}.
- TO_CYC, 24'd2_400_000, maximum cycles to wait on any RDY edge before flagging a timeout (100 ms at 24 MHz).

Ports:
- CLK  in  1  clock, 24 MHz.
- RST  in  1  reset, synchronous, active-high.
- TEMP  in  TEMP_W  signed temperature sample.
- TEMP_VLD  in  1  one-cycle strobe; TEMP is valid in that cycle.
- LCD_RDY  in  1  RDY from the LCD controller; high = idle.
- LCD_DATA  out  8  character or instruction byte.
- LCD_OPER  out  2  2'd1 = write character, 2'd2 = write instruction, 2'd0 = idle.
- LCD_ENB  out  1  one-cycle request strobe.
- BUSY  out  1  high from capture until the last character is accepted.
- TO_ERR  out  1  sticky timeout flag; cleared only by RST.

Behaviour:
- Reset values: LCD_DATA=0, LCD_OPER=0, LCD_ENB=0, BUSY=0, TO_ERR=0, pending flag cleared, FSM=IDLE.
- IDLE:
  - On TEMP_VLD, capture TEMP and go to CONV; BUSY rises the next cycle.
- Capture while BUSY:
  - A TEMP_VLD arriving when not in IDLE goes into a 1-deep pending register; the newest value wins.
  - On return to IDLE with pending set, start immediately from the pending value.
  - TEMP_VLD in the same cycle as the last character completing counts as pending.
- Arithmetic:
  - sign = TEMP[TEMP_W-1].
  - mag = sign ? -TEMP : TEMP, held as TEMP_W unsigned bits so the most negative value does not overflow.
  - ipart = mag >> 4.
  - fdig = (mag[3:0]*10) >> 4, i.e. tenths, truncated.
- CONV:
  - bin2bcd sub-module converts ipart to 3 BCD digits (double-dabble, 1 bit per cycle).
  - Wait for its done pulse.
- Send sequence, in order:
  - Instruction {1'b1, LINE_ADDR}.
  - Characters: 'T', '=', sign ('-' if negative, else '+'), hundreds, tens, ones (digit+8'h30, leading zeros kept), '.', fdig+8'h30, 8'hDF (degree), 'C'.
- Per item, the handshake substates are:
  - ISSUE: requires LCD_RDY=1. Drive LCD_DATA/LCD_OPER and pulse LCD_ENB for exactly 1 cycle. LCD_DATA/LCD_OPER hold until the item completes.
  - WAIT_LO: wait for LCD_RDY=0 (accepted).
  - WAIT_HI: wait for LCD_RDY=1 (done). Then advance the index.
  - If LCD_RDY=0 on entry to ISSUE, stay in ISSUE; ENB is never pulsed while RDY is low.
- Timeout:
  - A cycle counter runs in WAIT_LO and WAIT_HI and resets on every substate change.
  - On reaching TO_CYC: set TO_ERR, abandon the line, return to IDLE. Pending is still honoured.
- Completion: after the last item's WAIT_HI, set LCD_OPER=0, BUSY=0, return to IDLE.
- RST mid-sequence: synchronous abort to reset values; the LCD controller is left to its own reset.

Optional Feature:
- Macro LCDFEED_CLEAR_EN.
- Defined: a CLEAR instruction (8'h01, OPER=2'd2) is sent before the address instruction on every line, using the same handshake. Sequence length is 12 items.
- Undefined: 11 items; characters are overwritten in place.

Decomposition:
- Package lcd_pkg holds:
  - OPER encodings (OPER_IDLE, OPER_CHAR, OPER_INSTR).
  - LCD command constants (CLEAR 8'h01, SET_DDRAM 8'h80).
  - ASCII constants (CH_DEG 8'hDF, CH_ZERO 8'h30).
  - FSM state enum.
- One sub-module, bin2bcd: sequential, start/done handshake, 9-bit input, three 4-bit digit outputs.

Test Plan:
- TEMP=392 (24.5 °C), RDY model with 40-cycle busy: sequence 0x80, "T=+024.5", 0xDF, "C"; BUSY falls after the last RDY rise; ENB pulses = 11.
- TEMP=-200 (13'h1F38): characters "T=-012.5", 0xDF, "C".
- TEMP=-4096 and TEMP=4095: "-256.0" and "+255.9"; no overflow.
- Two TEMP_VLD pulses (100 then 160) during a line: the current line completes, then exactly one more line shows "+010.0"; the first pending value is discarded.
- LCD_RDY held high after ENB (never drops): after TO_CYC cycles TO_ERR=1, FSM back in IDLE; a fresh TEMP_VLD starts a new line.
- RST asserted during the 5th character: next cycle all outputs are at reset values; no ENB until a new TEMP_VLD.
